// File: rtl/vs_atom_selector.sv
// Streaming argmax over one pass of inner products; appends the winning column to the support set.
// Optional VS_ATOM_SELECTOR_THRESHOLD_EN adds a magnitude threshold that halts support growth.
module vs_atom_selector #(
  parameter int unsigned COLUMNS           = 256,
  parameter int unsigned MAX_ATOMS         = 64,
  parameter int unsigned Q                 = 15,
  parameter int unsigned FP_DATA_BUS_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         clear_support,
  input  logic                         in_valid,
  input  logic [7:0]                   in_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0] in_data,
`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
  input  logic [FP_DATA_BUS_WIDTH-1:0] threshold,
  output logic                         below_threshold,
`endif
  output logic                         busy,
  output logic                         sel_valid,
  output logic                         sel_none,
  output logic [7:0]                   sel_index,
  output logic [FP_DATA_BUS_WIDTH-1:0] sel_magnitude,
  output logic [7:0]                   support_count,
  output logic                         support_full,
  input  logic [7:0]                   support_rd_addr,
  output logic [7:0]                   support_rd_data
);

  localparam int unsigned W      = FP_DATA_BUS_WIDTH;
  localparam int unsigned ListAw = (MAX_ATOMS > 1) ? $clog2(MAX_ATOMS) : 1;
  localparam logic [8:0] LastBeat = 9'(COLUMNS - 1);
  localparam logic [8:0] NumCols  = 9'(COLUMNS);
  localparam logic [8:0] NumAtoms = 9'(MAX_ATOMS);
  localparam logic [W-1:0] MagMax = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

  if (COLUMNS == 0 || COLUMNS > 256 || MAX_ATOMS == 0 || MAX_ATOMS > 255 || Q >= W)
  begin : g_bad_cfg
    $error("vs_atom_selector: unsupported parameter combination");
  end

  typedef enum logic [0:0] {StIdle, StScan} state_e;
  state_e state_q, state_d;

  logic [8:0]   beat_cnt_q, beat_cnt_d;
  logic         best_valid_q, best_valid_d;
  logic [7:0]   best_idx_q, best_idx_d;
  logic [W-1:0] best_mag_q, best_mag_d;
  logic [255:0] bitmap_q, bitmap_d;
  logic [7:0]   count_q, count_d;
  logic [7:0]   list_q [MAX_ATOMS];

  logic         sel_valid_q, sel_none_q, below_q;
  logic [7:0]   sel_index_q;
  logic [W-1:0] sel_mag_q;

  logic [W-1:0] abs_mag;
  logic         eligible, beat, take, last_beat, full, do_clear, do_start;
  logic         fin_valid, below, append;
  logic [7:0]   fin_idx;
  logic [W-1:0] fin_mag;

  // Most negative input has no positive twin; clamp it.
  always_comb begin
    abs_mag = in_data;
    if (in_data == MinNeg)  abs_mag = MagMax;
    else if (in_data[W-1])  abs_mag = -in_data;
  end

  always_comb begin
    eligible  = ({1'b0, in_addr} < NumCols) && !bitmap_q[in_addr];
    beat      = (state_q == StScan) && in_valid;
    take      = beat && eligible &&
                (!best_valid_q || (abs_mag > best_mag_q) ||
                 ((abs_mag == best_mag_q) && (in_addr < best_idx_q)));
    fin_valid = best_valid_q || take;
    fin_idx   = take ? in_addr : best_idx_q;
    fin_mag   = take ? abs_mag : best_mag_q;
    last_beat = beat && (beat_cnt_q == LastBeat);
    full      = ({1'b0, count_q} == NumAtoms);
    do_clear  = (state_q == StIdle) && clear_support;
    // A simultaneous clear empties the support first, so a full support no longer blocks start.
    do_start  = (state_q == StIdle) && start && (clear_support || !full);
`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
    below     = fin_valid && (fin_mag < threshold);
`else
    below     = 1'b0;
`endif
    append    = last_beat && fin_valid && !below;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (do_start) state_d = StScan;
      StScan:  if (last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StScan);
  end

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    best_valid_d = best_valid_q;
    best_idx_d   = best_idx_q;
    best_mag_d   = best_mag_q;
    if (do_start) begin
      beat_cnt_d   = '0;
      best_valid_d = 1'b0;
      best_idx_d   = '0;
      best_mag_d   = '0;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 9'd1;
      if (take) begin
        best_valid_d = 1'b1;
        best_idx_d   = in_addr;
        best_mag_d   = abs_mag;
      end
    end
  end

  always_comb begin
    bitmap_d = bitmap_q;
    count_d  = count_q;
    if (do_clear) begin
      bitmap_d = '0;
      count_d  = '0;
    end else if (append) begin
      bitmap_d[fin_idx] = 1'b1;
      count_d           = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q   <= '0;
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_mag_q   <= '0;
      bitmap_q     <= '0;
      count_q      <= '0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      best_valid_q <= best_valid_d;
      best_idx_q   <= best_idx_d;
      best_mag_q   <= best_mag_d;
      bitmap_q     <= bitmap_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MAX_ATOMS); i++) list_q[i] <= '0;
    end else if (append) begin
      list_q[count_q[ListAw-1:0]] <= fin_idx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_valid_q <= 1'b0;
      sel_none_q  <= 1'b0;
      below_q     <= 1'b0;
      sel_index_q <= '0;
      sel_mag_q   <= '0;
    end else begin
      sel_valid_q <= last_beat;
      if (last_beat) begin
        sel_none_q  <= !fin_valid;
        below_q     <= below;
        sel_index_q <= fin_valid ? fin_idx : 8'd0;
        sel_mag_q   <= fin_valid ? fin_mag : '0;
      end
    end
  end

  always_comb begin
    sel_valid       = sel_valid_q;
    sel_none        = sel_none_q;
    sel_index       = sel_index_q;
    sel_magnitude   = sel_mag_q;
    support_count   = count_q;
    support_full    = full;
    support_rd_data = ({1'b0, support_rd_addr} < NumAtoms) ?
                      list_q[support_rd_addr[ListAw-1:0]] : 8'd0;
  end

`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
  always_comb begin
    below_threshold = below_q;
  end
`else
  logic unused_below;
  always_comb begin
    unused_below = below_q;
  end
`endif

endmodule

// File: tb/tb_vs_atom_selector.sv
// Scoreboard bench: u_dut_a (8 columns, 3 atoms) and u_dut_b (8 columns, 8 atoms) share the beat bus.
module tb_vs_atom_selector;

  localparam int Cols = 8;

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] mag;
    logic        none;
    logic        below;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, in_valid;
  logic [7:0]  in_addr;
  logic [31:0] in_data;
  logic [31:0] thr = '0;
  logic        start_a, clear_a, start_b, clear_b;
  logic        busy_a, sel_valid_a, sel_none_a, full_a;
  logic        busy_b, sel_valid_b, sel_none_b, full_b;
  logic [7:0]  sel_index_a, count_a, rd_addr_a, rd_data_a;
  logic [7:0]  sel_index_b, count_b, rd_addr_b, rd_data_b;
  logic [31:0] sel_mag_a, sel_mag_b;
`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
  logic        below_a, below_b;
`endif

  exp_t         q_a[$], q_b[$];
  logic [255:0] bm_a, bm_b;
  int           cnt_a, cnt_b;
  int           total = 0, bad = 0;

  vs_atom_selector #(.COLUMNS(8), .MAX_ATOMS(3)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .clear_support(clear_a),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
    .threshold(thr), .below_threshold(below_a),
`endif
    .busy(busy_a), .sel_valid(sel_valid_a), .sel_none(sel_none_a), .sel_index(sel_index_a),
    .sel_magnitude(sel_mag_a), .support_count(count_a), .support_full(full_a),
    .support_rd_addr(rd_addr_a), .support_rd_data(rd_data_a)
  );

  vs_atom_selector #(.COLUMNS(8), .MAX_ATOMS(8)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .clear_support(clear_b),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
    .threshold(thr), .below_threshold(below_b),
`endif
    .busy(busy_b), .sel_valid(sel_valid_b), .sel_none(sel_none_b), .sel_index(sel_index_b),
    .sel_magnitude(sel_mag_b), .support_count(count_b), .support_full(full_b),
    .support_rd_addr(rd_addr_b), .support_rd_data(rd_data_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mag_of(input logic [31:0] d);
    if (d == 32'h8000_0000) return 32'h7fff_ffff;
    if (d[31]) return -d;
    return d;
  endfunction

  // Results are compared in the cycle the DUT flags them.
  always @(negedge clock) begin
    exp_t e;
    if (sel_valid_a) begin
      if (q_a.size() == 0) check_eq("a_unexpected_sel", 32'(sel_valid_a), 0);
      else begin
        e = q_a.pop_front();
        check_eq("a_sel_index", 32'(sel_index_a), 32'(e.idx));
        check_eq("a_sel_mag", sel_mag_a, e.mag);
        check_eq("a_sel_none", 32'(sel_none_a), 32'(e.none));
        check_eq("a_busy_at_sel", 32'(busy_a), 0);
`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
        check_eq("a_below", 32'(below_a), 32'(e.below));
`endif
      end
    end
    if (sel_valid_b) begin
      if (q_b.size() == 0) check_eq("b_unexpected_sel", 32'(sel_valid_b), 0);
      else begin
        e = q_b.pop_front();
        check_eq("b_sel_index", 32'(sel_index_b), 32'(e.idx));
        check_eq("b_sel_mag", sel_mag_b, e.mag);
        check_eq("b_sel_none", 32'(sel_none_b), 32'(e.none));
`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
        check_eq("b_below", 32'(below_b), 32'(e.below));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_pass(input bit on_b, input logic [31:0] data[8], input logic [7:0] addr[8],
                          input bit gap, input bit clr);
    exp_t         e;
    logic [255:0] bm;
    logic         bv;
    logic [7:0]   bi;
    logic [31:0]  bmag, m;
    if (clr) begin
      if (on_b) begin bm_b = '0; cnt_b = 0; end
      else      begin bm_a = '0; cnt_a = 0; end
    end
    bm = on_b ? bm_b : bm_a;
    bv = 1'b0; bi = '0; bmag = '0;
    for (int i = 0; i < 8; i++) begin
      if (addr[i] < Cols && !bm[addr[i]]) begin
        m = mag_of(data[i]);
        if (!bv || m > bmag || (m == bmag && addr[i] < bi)) begin
          bv = 1'b1; bi = addr[i]; bmag = m;
        end
      end
    end
    e.none  = !bv;
    e.idx   = bv ? bi : 8'd0;
    e.mag   = bv ? bmag : 32'd0;
    e.below = bv && (bmag < thr);
    if (bv && !e.below) begin
      if (on_b) begin bm_b[bi] = 1'b1; cnt_b++; end
      else      begin bm_a[bi] = 1'b1; cnt_a++; end
    end
    if (on_b) q_b.push_back(e); else q_a.push_back(e);

    if (on_b) begin start_b = 1'b1; clear_b = clr; end
    else      begin start_a = 1'b1; clear_a = clr; end
    tick();
    start_a = 1'b0; start_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
    check_eq(on_b ? "b_busy_scan" : "a_busy_scan", 32'(on_b ? busy_b : busy_a), 1);
    for (int i = 0; i < 8; i++) begin
      if (gap && i == 3) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1; in_addr = addr[i]; in_data = data[i];
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((on_b ? q_b.size() : q_a.size()) == 0) break;
      tick();
    end
    if ((on_b ? q_b.size() : q_a.size()) != 0) begin
      check_eq("result_timeout", 32'(on_b ? q_b.size() : q_a.size()), 0);
      if (on_b) q_b.delete(); else q_a.delete();
    end
    check_eq(on_b ? "b_count" : "a_count", 32'(on_b ? count_b : count_a),
             32'(on_b ? cnt_b : cnt_a));
  endtask

  task automatic idle_start_ignored(input bit on_b);
    if (on_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq(on_b ? "b_busy_ignored" : "a_busy_ignored", 32'(on_b ? busy_b : busy_a), 0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d_main[8], d_neg[8], d_b[8];
    logic [7:0]  seq[8], far[8];
    d_main = '{32'd3, -32'sd9, 32'd4, 32'd0, 32'd9, -32'sd2, 32'd1, 32'd5};
    d_neg  = '{32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    d_b    = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd0, 32'd1};
    for (int i = 0; i < 8; i++) begin
      seq[i] = 8'(i);
      far[i] = 8'(i + 8);
    end
    bm_a = '0; bm_b = '0; cnt_a = 0; cnt_b = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    start_a = 1'b0; clear_a = 1'b0; start_b = 1'b0; clear_b = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    #12;
    check_eq("rst_busy", 32'(busy_a), 0);
    check_eq("rst_sel_valid", 32'(sel_valid_a), 0);
    check_eq("rst_sel_index", 32'(sel_index_a), 0);
    check_eq("rst_sel_mag", sel_mag_a, 0);
    check_eq("rst_count", 32'(count_a), 0);
    check_eq("rst_full", 32'(full_a), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Tie at magnitude 9 between columns 1 and 4 resolves to the lower index.
    run_pass(0, d_main, seq, 0, 0);
    check_eq("p1_idx", 32'(sel_index_a), 1);
    check_eq("p1_mag", sel_mag_a, 9);
    check_eq("p1_rd0", 32'(rd_data_a), 1);
    run_pass(0, d_main, seq, 1, 0);
    check_eq("p2_idx", 32'(sel_index_a), 4);
    run_pass(0, d_main, seq, 0, 0);
    check_eq("p3_idx", 32'(sel_index_a), 7);
    check_eq("p3_mag", sel_mag_a, 5);
    check_eq("p3_full", 32'(full_a), 1);
    rd_addr_a = 8'd2; #1;
    check_eq("p3_rd2", 32'(rd_data_a), 7);
    rd_addr_a = 8'd1; #1;
    check_eq("p3_rd1", 32'(rd_data_a), 4);
    idle_start_ignored(0);

    clear_a = 1'b1;
    tick();
    clear_a = 1'b0; bm_a = '0; cnt_a = 0;
    check_eq("clr_count", 32'(count_a), 0);
    check_eq("clr_full", 32'(full_a), 0);
    run_pass(0, d_neg, seq, 0, 0);
    check_eq("neg_idx", 32'(sel_index_a), 0);
    check_eq("neg_mag", sel_mag_a, 32'h7fff_ffff);
    run_pass(0, d_main, far, 0, 0);
    check_eq("none_flag", 32'(sel_none_a), 1);
    check_eq("none_idx", 32'(sel_index_a), 0);

    for (int p = 0; p < 8; p++) run_pass(1, d_b, seq, p[0], 0);
    check_eq("b8_idx", 32'(sel_index_b), 6);
    check_eq("b8_full", 32'(full_b), 1);
    rd_addr_b = 8'd7; #1;
    check_eq("b8_rd7", 32'(rd_data_b), 6);
    idle_start_ignored(1);
    run_pass(1, d_b, seq, 0, 1);
    check_eq("b_clrstart_idx", 32'(sel_index_b), 0);
    check_eq("b_clrstart_mag", sel_mag_b, 8);

    // Abandon a pass partway through.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = seq[i]; in_data = d_main[i];
      tick();
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    check_eq("midrst_busy", 32'(busy_a), 0);
    check_eq("midrst_count", 32'(count_a), 0);
    check_eq("midrst_sel_valid", 32'(sel_valid_a), 0);
    tick();
    reset_n = 1'b1;
    bm_a = '0; bm_b = '0; cnt_a = 0; cnt_b = 0;
    tick();
    run_pass(0, d_main, seq, 0, 0);
    check_eq("post_rst_idx", 32'(sel_index_a), 1);

`ifdef VS_ATOM_SELECTOR_THRESHOLD_EN
    thr = 32'd10;
    run_pass(0, d_main, seq, 0, 0);
    check_eq("thr_below", 32'(below_a), 1);
    check_eq("thr_count", 32'(count_a), 1);
    thr = '0;
`endif

    repeat (3) tick();
    check_eq("a_queue_empty", 32'(q_a.size()), 0);
    check_eq("b_queue_empty", 32'(q_b.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
